dma_desc_chunker: RTL
=====================

Name: dma_desc_chunker

Overview:
- Sits between the descriptor FIFO (first-word-fall-through, not_empty/rdack) and the DMA engine's command input.
- Pops one descriptor at a time and splits it into legal burst commands. Each burst is no longer than MAX_BURST lines and never crosses a 4 KB boundary on either the source or the destination address.
- Reports per-descriptor completion and malformed-descriptor errors to the CSR status path.

Parameters:
- ADDR_W, 64, byte address width of src/dest.
- LEN_W, 32, descriptor length width in 64-byte lines.
- MAX_BURST, 64, maximum lines per burst; power of 2, 1..64.
- BURST_W, 7, width of cmd_len; must hold MAX_BURST.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- stop  in  1  CSR stop_descriptors; blocks new descriptor pops.
- in_not_empty  in  1  descriptor FIFO has an entry.
- in_rdack  out  1  one-cycle dequeue pulse to the FIFO.
- in_src_addr  in  ADDR_W  descriptor source byte address.
- in_dest_addr  in  ADDR_W  descriptor destination byte address.
- in_len  in  LEN_W  descriptor length in lines.
- in_mode  in  2  copy direction, passed through.
- cmd_valid  out  1  burst command valid.
- cmd_ready  in  1  engine accepts the command.
- cmd_src_addr  out  ADDR_W  burst source address.
- cmd_dest_addr  out  ADDR_W  burst destination address.
- cmd_len  out  BURST_W  burst length in lines, 1..MAX_BURST.
- cmd_mode  out  2  copy mode.
- cmd_first  out  1  first burst of the descriptor.
- cmd_last  out  1  last burst of the descriptor.
- desc_done  out  1  one-cycle pulse after the last burst is accepted.
- desc_err  out  1  sticky malformed-descriptor flag.
- err_clr  in  1  clears desc_err.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE; all outputs 0; internal registers 0. Reset applies immediately at any point mid-descriptor; the partial descriptor is abandoned and no desc_done is issued.
- States: IDLE, CALC, ISSUE.
- IDLE, when in_not_empty && !stop:
  - Drive in_rdack=1 combinationally for exactly this cycle.
  - Capture in_* into src/dst/rem/mode registers; set first_flag=1.
  - If in_len==0, or in_src_addr[5:0]!=0, or in_dest_addr[5:0]!=0: set desc_err and stay in IDLE. No cmd is issued and no desc_done. The descriptor is still dequeued.
  - Otherwise go to CALC.
- stop only gates IDLE. A descriptor already in progress always runs to completion.
- CALC (one cycle):
  - sb = 64 - src[11:6]; db = 64 - dst[11:6].
  - burst = min(rem, MAX_BURST, sb, db).
  - Register cmd_* fields; cmd_first=first_flag; cmd_last=(rem==burst).
  - Next state ISSUE.
- ISSUE:
  - cmd_valid=1. All cmd_* fields are held stable until cmd_ready.
  - On cmd_valid && cmd_ready:
    - src += burst*64; dst += burst*64; rem -= burst; first_flag=0.
    - If cmd_last: next IDLE, and desc_done pulses on the following cycle.
    - Otherwise: next CALC.
  - cmd_valid drops the cycle after acceptance.
- Latency: a FIFO entry visible at cycle N (with IDLE and !stop) gives rdack at N and cmd_valid at N+2.
- Throughput: at most one burst per 2 cycles. Back-to-back descriptors have one IDLE cycle between them.
- Address arithmetic wraps modulo 2^ADDR_W with no error. rem never underflows, because burst <= rem.
- err_clr and a new error in the same cycle: set wins. desc_err is otherwise held.
- busy=1 in CALC and ISSUE.

Optional Feature:
- Macro DMA_CHUNK_PERF_EN.
- When defined, add the following outputs:
  - burst_cnt[31:0]: increments on each accepted cmd.
  - stall_cnt[31:0]: increments each cycle with cmd_valid && !cmd_ready.
  - Both counters saturate at all-ones, clear on reset, and also clear on err_clr.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Aligned single burst: src=0x1000, dst=0x8000, len=16, cmd_ready=1 -> one cmd: len=16, first=1, last=1; rdack at N, cmd_valid at N+2; desc_done one cycle after accept.
- 4 KB split on src: src=0x1F80, dst=0x10000, len=10 -> cmds (0x1F80, 0x10000, 2) then (0x2000, 0x10080, 8); first/last flags correct on each.
- MAX_BURST split with backpressure: len=200, addresses aligned at 4 KB, cmd_ready held low 5 cycles per cmd -> cmds 64, 64, 64, 8; fields stable while stalled; exactly one desc_done.
- Malformed descriptors: len=0, then src=0x1004 -> each rdack'd, no cmd_valid, desc_err=1; err_clr -> desc_err=0.
- Stop and reset: stop=1 with FIFO non-empty -> no rdack. stop asserted mid-descriptor -> remaining bursts still issued. reset asserted during ISSUE -> cmd_valid=0 and busy=0 immediately, no desc_done.
- DMA_CHUNK_PERF_EN defined: the 200-line case gives burst_cnt=4 and stall_cnt=20.

Source files
------------

// File: rtl/dma_desc_chunker.sv
// Splits DMA descriptors into bursts of at most MAX_BURST lines that never cross a 4 KB page
// on source or destination. Optional perf counters are enabled by defining DMA_CHUNK_PERF_EN.
module dma_desc_chunker #(
    parameter int ADDR_W    = 64,
    parameter int LEN_W     = 32,
    parameter int MAX_BURST = 64,
    parameter int BURST_W   = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stop,
    input  logic              in_not_empty,
    output logic              in_rdack,
    input  logic [ADDR_W-1:0] in_src_addr,
    input  logic [ADDR_W-1:0] in_dest_addr,
    input  logic [LEN_W-1:0]  in_len,
    input  logic [1:0]        in_mode,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_src_addr,
    output logic [ADDR_W-1:0] cmd_dest_addr,
    output logic [BURST_W-1:0] cmd_len,
    output logic [1:0]        cmd_mode,
    output logic              cmd_first,
    output logic              cmd_last,
    output logic              desc_done,
    output logic              desc_err,
    input  logic              err_clr,
`ifdef DMA_CHUNK_PERF_EN
    output logic [31:0]       burst_cnt,
    output logic [31:0]       stall_cnt,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [1:0]         mode_q, mode_d;
    logic               first_q, first_d;
    logic [ADDR_W-1:0]  cmd_src_q, cmd_src_d, cmd_dst_q, cmd_dst_d;
    logic [BURST_W-1:0] cmd_len_q, cmd_len_d;
    logic [1:0]         cmd_mode_q, cmd_mode_d;
    logic               cmd_first_q, cmd_first_d, cmd_last_q, cmd_last_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               rdack_s;
    logic               bad_desc_s;
    logic [LEN_W-1:0]   sb_s, db_s, burst_s;
    logic [ADDR_W-1:0]  step_s;

    // Burst size: lines left in both 4 KB pages, capped by MAX_BURST and remaining length
    always_comb begin
        sb_s    = LEN_W'(7'd64) - LEN_W'(src_q[11:6]);
        db_s    = LEN_W'(7'd64) - LEN_W'(dst_q[11:6]);
        burst_s = rem_q;
        if (burst_s > LEN_W'(MAX_BURST)) begin
            burst_s = LEN_W'(MAX_BURST);
        end else begin
            burst_s = burst_s;
        end
        if (burst_s > sb_s) begin
            burst_s = sb_s;
        end else begin
            burst_s = burst_s;
        end
        if (burst_s > db_s) begin
            burst_s = db_s;
        end else begin
            burst_s = burst_s;
        end
    end

    assign step_s     = ADDR_W'({cmd_len_q, 6'd0});
    assign bad_desc_s = (in_len == LEN_W'(0)) || (in_src_addr[5:0] != 6'd0) ||
                        (in_dest_addr[5:0] != 6'd0);

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        rem_d       = rem_q;
        mode_d      = mode_q;
        first_d     = first_q;
        cmd_src_d   = cmd_src_q;
        cmd_dst_d   = cmd_dst_q;
        cmd_len_d   = cmd_len_q;
        cmd_mode_d  = cmd_mode_q;
        cmd_first_d = cmd_first_q;
        cmd_last_d  = cmd_last_q;
        cmd_valid_d = 1'b0;
        done_d      = 1'b0;
        rdack_s     = 1'b0;
        err_d       = err_clr ? 1'b0 : err_q;
        case (state_q)
            IDLE: begin
                if (in_not_empty && !stop) begin
                    rdack_s = 1'b1;
                    src_d   = in_src_addr;
                    dst_d   = in_dest_addr;
                    rem_d   = in_len;
                    mode_d  = in_mode;
                    first_d = 1'b1;
                    if (bad_desc_s) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                cmd_src_d   = src_q;
                cmd_dst_d   = dst_q;
                cmd_len_d   = burst_s[BURST_W-1:0];
                cmd_mode_d  = mode_q;
                cmd_first_d = first_q;
                cmd_last_d  = (rem_q == burst_s);
                cmd_valid_d = 1'b1;
                state_d     = ISSUE;
            end
            ISSUE: begin
                if (cmd_ready) begin
                    src_d   = src_q + step_s;
                    dst_d   = dst_q + step_s;
                    rem_d   = rem_q - LEN_W'(cmd_len_q);
                    first_d = 1'b0;
                    if (cmd_last_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = CALC;
                    end
                end else begin
                    cmd_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            rem_q       <= '0;
            mode_q      <= 2'd0;
            first_q     <= 1'b0;
            cmd_src_q   <= '0;
            cmd_dst_q   <= '0;
            cmd_len_q   <= '0;
            cmd_mode_q  <= 2'd0;
            cmd_first_q <= 1'b0;
            cmd_last_q  <= 1'b0;
            cmd_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            rem_q       <= rem_d;
            mode_q      <= mode_d;
            first_q     <= first_d;
            cmd_src_q   <= cmd_src_d;
            cmd_dst_q   <= cmd_dst_d;
            cmd_len_q   <= cmd_len_d;
            cmd_mode_q  <= cmd_mode_d;
            cmd_first_q <= cmd_first_d;
            cmd_last_q  <= cmd_last_d;
            cmd_valid_q <= cmd_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

`ifdef DMA_CHUNK_PERF_EN
    logic [31:0] burst_cnt_q, stall_cnt_q;

    // Saturating accepted-burst and backpressure-stall counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else if (err_clr) begin
            burst_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (cmd_valid_q && cmd_ready && (burst_cnt_q != 32'hFFFF_FFFF)) begin
                burst_cnt_q <= burst_cnt_q + 32'd1;
            end else begin
                burst_cnt_q <= burst_cnt_q;
            end
            if (cmd_valid_q && !cmd_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
        end
    end

    assign burst_cnt = burst_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

    // rdack is combinational so the FIFO pops in the same cycle the entry is captured
    assign in_rdack      = rdack_s && !reset;
    assign cmd_valid     = cmd_valid_q;
    assign cmd_src_addr  = cmd_src_q;
    assign cmd_dest_addr = cmd_dst_q;
    assign cmd_len       = cmd_len_q;
    assign cmd_mode      = cmd_mode_q;
    assign cmd_first     = cmd_first_q;
    assign cmd_last      = cmd_last_q;
    assign desc_done     = done_q;
    assign desc_err      = err_q;
    assign busy          = busy_q;

endmodule
